// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter.
// State encoding, default sizes and the grant index type.
package uart_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    ACK
  } state_t;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] grant_idx_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or above ptr.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_valid
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest candidate down so the nearest one wins last.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (valid[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Optional watchdog on tx_done: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16,
  localparam int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic [CNT_W-1:0]          sent_cnt,
  output logic                      timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick;
  logic               any_valid;
  logic               tx_done_q;
  logic               done_edge;
  logic [NUM_REQ-1:0] ack_mask;
  logic [IDX_W-1:0]   next_ptr;
  logic [DATA_W-1:0]  req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick),
    .any_valid (any_valid)
  );

  // A held-high tx_done must not complete a second byte.
  assign done_edge = tx_done & ~tx_done_q;
  assign ack_mask  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign next_ptr  = IDX_W'(wrap_inc(int'(grant_id), NUM_REQ));
  assign busy      = (state != IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            to_err_q;

  assign to_hit      = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = to_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == START) begin
      to_cnt <= '0;
    end else if (state == WAIT_DONE && !to_hit) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      req_ack   <= '0;
      grant_id  <= '0;
      sent_cnt  <= '0;
      tx_done_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_err_q  <= 1'b0;
`endif
    end else begin
      tx_done_q <= tx_done;
      tx_start  <= 1'b0;
      req_ack   <= '0;
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= pick;
            tx_data  <= req_bytes[pick];
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_edge) begin
            req_ack  <= ack_mask;
            sent_cnt <= sent_cnt + CNT_W'(1);
            state    <= ACK;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (to_hit) begin
            req_ack  <= ack_mask;
            to_err_q <= 1'b1;
            state    <= ACK;
          end
`endif
        end
        ACK: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (tx_data/tx_start/tx_done) of uartprotocoltop among NUM_REQ byte requesters.
- Round-robin grant, one byte per grant; drives tx_start/tx_data, waits for transmitter completion, acknowledges the granted requester.
- Sits between on-chip byte producers and the UART top; rx path untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; matches UART tx_data.
- TIMEOUT_CYCLES, 4096, cycles allowed between tx_start and tx_done edge (used only with optional feature).
- CNT_W, 16, width of sent-byte counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte pending; held until req_ack.
- req_data  in  NUM_REQ*DATA_W  packed bytes, requester i at [i*DATA_W +: DATA_W]; stable while valid.
- req_ack  out  NUM_REQ  one-cycle pulse: byte of that requester fully transmitted.
- tx_start  out  1  one-cycle start pulse to UART.
- tx_data  out  DATA_W  byte to UART, registered, held from tx_start until next grant.
- tx_done  in  1  UART completion flag (level or pulse).
- busy  out  1  high in any state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of current/last grant.
- sent_cnt  out  CNT_W  total bytes acknowledged, wraps at 2^CNT_W.
- timeout_err  out  1  sticky timeout flag (tied 0 without optional feature).

Behaviour:
- Reset (async, rst=1): state IDLE, rr pointer=0, tx_start=0, tx_data=0, req_ack=0, grant_id=0, sent_cnt=0, timeout_err=0, tx_done_q=0.
- tx_done edge: tx_done_q registers tx_done every cycle; done_edge = tx_done & ~tx_done_q. Only done_edge is used; a held level never counts twice.
- FSM IDLE -> START -> WAIT_DONE -> ACK -> IDLE.
- IDLE: if any req_valid, pick first valid index searching from rr pointer upward, mod NUM_REQ; latch grant_id and tx_data; go START. No valid: stay.
- START: tx_start=1 for exactly this cycle; go WAIT_DONE.
- WAIT_DONE: done_edge -> ACK. Any done_edge seen in IDLE/START is ignored.
- ACK: req_ack[grant_id]=1 for this cycle; sent_cnt+1 (wrap); rr pointer = grant_id+1 mod NUM_REQ; go IDLE.
- Latency: req_valid high in cycle N (IDLE) -> tx_start in N+1; done_edge cycle M -> req_ack in M+1. Minimum spacing between tx_start pulses: 4 cycles.
- Requester drops req_valid after grant: byte still sent, ack still pulsed.
- All valid simultaneously: strict rotation 0,1,2,3,0...
- Reset mid-transfer: FSM returns to IDLE immediately, no ack issued; the UART's own rst is responsible for aborting the serial frame.

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- Defined: cycle counter cleared in START, increments in WAIT_DONE. If it reaches TIMEOUT_CYCLES-1 without done_edge: go ACK (ack pulsed, sent_cnt NOT incremented), timeout_err set sticky until rst.
- Undefined: no counter; WAIT_DONE waits indefinitely; timeout_err constant 0.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, START, WAIT_DONE, ACK), default NUM_REQ/DATA_W constants, grant index typedef.
- One sub-module rr_arbiter: combinational pick of the first valid from pointer, outputs grant index + any_valid; pointer register stays in the parent.

Test Plan:
- Single req_valid[2]=1, data 0xA5 -> tx_start 1 cycle later with tx_data=0xA5, grant_id=2; after tx_done edge, req_ack[2] next cycle, sent_cnt=1.
- All four valid, data 0x10..0x13 -> transmitted in order 0x10,0x11,0x12,0x13, then 0x10 again if still valid.
- tx_done held high for 20 cycles across the next grant -> exactly one ack per byte, second byte waits for a fresh edge.
- req_valid[1] drops 2 cycles after tx_start -> byte still completes, req_ack[1] pulsed.
- rst asserted during WAIT_DONE -> all outputs 0 asynchronously, no ack, next valid restarts from requester 0.
- With UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, tx_done never rises -> ack after 16 cycles in WAIT_DONE, timeout_err=1, sent_cnt unchanged.
